// File: rtl/berger_pkg.sv
// Shared definitions for the Berger-zero memory BIST controller and its benches.
package berger_pkg;

    // Controller state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Phase-0 pattern; phase 1 writes its complement so every cell toggles
    localparam logic [7:0] BERGER_PATTERN = 8'hA5;

endpackage

// File: rtl/berger_bist_checker.sv
// Read-back checker: compares against the phase pattern, counts failing
// reads, keeps the sticky Berger flag and captures the first failure.
module berger_bist_checker
    import berger_pkg::*;
#(
    parameter int              ADDR_W  = 4,
    parameter int              DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(BERGER_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              chk_en,
    input  logic              clr,
    input  logic              ph,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              err,
    output logic [ADDR_W+1:0] err_count,
    output logic              berger_err_seen,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_phase
);

    logic [DATA_W-1:0] expected;
    logic              fail;

    // A mismatch and a decoder flag on the same read count as one failure
    always_comb begin
        expected = ph ? ~PATTERN : PATTERN;
        fail     = chk_en && ((rd_data != expected) || err);
    end

    // Result registers, cleared by reset or by an accepted start
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count       <= '0;
            berger_err_seen <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            first_err_phase <= 1'b0;
        end else if (fail) begin
            err_count       <= err_count + 1'b1;
            berger_err_seen <= berger_err_seen | err;
            if (!first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_addr  <= a;
                first_err_phase <= ph;
            end
        end
    end

endmodule

// File: rtl/berger_zero_bist_ctrl.sv
// Two-phase pattern BIST sequencer for the Berger-zero protected memory.
//
// state | meaning
// IDLE  | waiting for start, results held
// WR    | writing the phase pattern at address a, one word per cycle
// RD    | read address a held while the read latency elapses
// CHK   | read data valid for address a, compared by the checker
// DONE  | one-cycle done pulse, pass registered
module berger_zero_bist_ctrl
    import berger_pkg::*;
#(
    parameter int              ADDR_W  = 4,
    parameter int              DATA_W  = 8,
    parameter int              DEPTH   = 16,
    parameter int              RD_LAT  = 1,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(BERGER_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_err,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count,
    output logic              berger_err_seen,
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_phase
);

    localparam int LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int LAT_LOAD = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // With zero read latency the data is already valid, so RD is skipped
    localparam logic [2:0] ST_READ = (RD_LAT == 0) ? ST_CHK : ST_RD;

    logic [2:0]        state;
    logic              ph;
    logic [ADDR_W-1:0] a;
    logic [LAT_W-1:0]  lat_cnt;
    logic              accept;

    assign accept = (state == ST_IDLE) && start;

    // Sequencer: state, phase, address counter and read-latency down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ph      <= 1'b0;
            a       <= '0;
            lat_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_WR;
                        ph    <= 1'b0;
                        a     <= '0;
                        pass  <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (a == LAST_ADDR) begin
                        a       <= '0;
                        lat_cnt <= LAT_W'(LAT_LOAD);
                        state   <= ST_READ;
                    end else begin
                        a <= a + 1'b1;
                    end
                end
                ST_RD: begin
                    if (lat_cnt == '0) begin
                        state <= ST_CHK;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_CHK: begin
                    if (a != LAST_ADDR) begin
                        a       <= a + 1'b1;
                        lat_cnt <= LAT_W'(LAT_LOAD);
                        state   <= ST_READ;
                    end else if (!ph) begin
                        ph    <= 1'b1;
                        a     <= '0;
                        state <= ST_WR;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    pass  <= (err_count == '0);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory-side and status outputs decoded from the current state
    always_comb begin
        busy        = (state == ST_WR) || (state == ST_RD) || (state == ST_CHK);
        done        = (state == ST_DONE);
        mem_wr_en   = (state == ST_WR);
        mem_addr    = busy ? a : '0;
        mem_wr_data = mem_wr_en ? (ph ? ~PATTERN : PATTERN) : '0;
    end

    berger_bist_checker #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PATTERN (PATTERN)
    ) u_checker (
        .clk             (clk),
        .rst             (rst),
        .chk_en          (state == ST_CHK),
        .clr             (accept),
        .ph              (ph),
        .a               (a),
        .rd_data         (mem_rd_data),
        .err             (mem_err),
        .err_count       (err_count),
        .berger_err_seen (berger_err_seen),
        .first_err_valid (first_err_valid),
        .first_err_addr  (first_err_addr),
        .first_err_phase (first_err_phase)
    );

endmodule

// File: tb/tb_berger_zero_bist_ctrl.sv
// Directed bench: three controllers (RD_LAT 1, 0, 2) each driving a small
// behavioural memory; the RD_LAT=1 one also sees a zero-to-one fault injector.
module tb_berger_zero_bist_ctrl;
    import berger_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] start_v = 3'b000;
    logic [2:0] wr_en_v, busy_v, done_v, pass_v, seen_v, fev_v, fep_v, err_v;
    logic [3:0] addr_v [3];
    logic [3:0] fea_v  [3];
    logic [7:0] wr_data_v [3];
    logic [7:0] rd_data_v [3];
    logic [5:0] cnt_v [3];

    logic [7:0] mem [3][16];
    logic [3:0] ad1 [3];
    logic [3:0] ad2 [3];
    logic [7:0] raw0, mask_act;

    int fault_mode = 0;
    int rc = 0;
    int ncomp = 0;
    int nfail = 0;
    int runs [3] = '{0, 0, 0};
    int bad [3] = '{0, 0, 0};
    int run_len [3] = '{0, 0, 0};
    logic [2:0] rd_prev = 3'b000;
    logic [3:0] addr_prev [3] = '{4'd0, 4'd0, 4'd0};
    wire  [2:0] rd_cyc = busy_v & ~wr_en_v;

    berger_zero_bist_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .mem_wr_en(wr_en_v[0]), .mem_addr(addr_v[0]), .mem_wr_data(wr_data_v[0]),
        .mem_rd_data(rd_data_v[0]), .mem_err(err_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(cnt_v[0]),
        .berger_err_seen(seen_v[0]), .first_err_valid(fev_v[0]),
        .first_err_addr(fea_v[0]), .first_err_phase(fep_v[0])
    );

    berger_zero_bist_ctrl #(.RD_LAT(0)) dut_lat0 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .mem_wr_en(wr_en_v[1]), .mem_addr(addr_v[1]), .mem_wr_data(wr_data_v[1]),
        .mem_rd_data(rd_data_v[1]), .mem_err(err_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(cnt_v[1]),
        .berger_err_seen(seen_v[1]), .first_err_valid(fev_v[1]),
        .first_err_addr(fea_v[1]), .first_err_phase(fep_v[1])
    );

    berger_zero_bist_ctrl #(.RD_LAT(2)) dut_lat2 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .mem_wr_en(wr_en_v[2]), .mem_addr(addr_v[2]), .mem_wr_data(wr_data_v[2]),
        .mem_rd_data(rd_data_v[2]), .mem_err(err_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(cnt_v[2]),
        .berger_err_seen(seen_v[2]), .first_err_valid(fev_v[2]),
        .first_err_addr(fea_v[2]), .first_err_phase(fep_v[2])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 2);
    endfunction

    // Memory arrays and read-address pipelines
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr_en_v[i]) mem[i][addr_v[i]] <= wr_data_v[i];
            ad1[i] <= addr_v[i];
            ad2[i] <= ad1[i];
        end
    end

    // Read data per latency; zero-to-one fault injection on the RD_LAT=1 memory
    always_comb begin
        mask_act = 8'h00;
        if (fault_mode == 1)
            mask_act = 8'h01;
        else if (fault_mode == 2 && rc < 49 && addr_v[0] == 4'd3 && rd_cyc[0])
            mask_act = 8'h02;
        raw0         = mem[0][ad1[0]];
        rd_data_v[0] = raw0 | mask_act;
        rd_data_v[1] = mem[1][addr_v[1]];
        rd_data_v[2] = mem[2][ad2[2]];
        err_v        = 3'b000;
        err_v[0]     = (raw0 & mask_act) != mask_act;
    end

    // Address-hold monitor: every read run must last RD_LAT+1 cycles
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_prev[i] && (!rd_cyc[i] || addr_v[i] != addr_prev[i])) begin
                runs[i]++;
                if (run_len[i] != lat_of(i) + 1) bad[i]++;
            end
            if (rd_cyc[i])
                run_len[i] = (rd_prev[i] && addr_v[i] == addr_prev[i]) ? run_len[i] + 1 : 1;
            rd_prev[i]   = rd_cyc[i];
            addr_prev[i] = addr_v[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        rc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a test on instance idx and run it to the cycle after done
    task automatic run_test(input int idx, input bit extra, input bit start_in_done,
                            output int done_at, output int runs_d, output int bad_d);
        int r0, b0;
        rc = 0;
        start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
        r0 = runs[idx];
        b0 = bad[idx];
        while (done_v[idx] !== 1'b1 && rc < 400) begin
            if (extra && (rc == 10 || rc == 50)) start_v[idx] = 1'b1;
            step();
            start_v[idx] = 1'b0;
        end
        done_at = rc;
        if (start_in_done) start_v[idx] = 1'b1;
        step();
        start_v[idx] = 1'b0;
        runs_d = runs[idx] - r0;
        bad_d  = bad[idx] - b0;
    endtask

    task automatic check_res(input int idx, input string tag, input int cnt, input bit seen,
                             input bit fev, input int fea, input bit fep, input bit pas);
        check({tag, "_err_count"}, 32'(cnt_v[idx]), 32'(cnt));
        check({tag, "_berger_seen"}, 32'(seen_v[idx]), 32'(seen));
        check({tag, "_first_valid"}, 32'(fev_v[idx]), 32'(fev));
        if (fev) begin
            check({tag, "_first_addr"}, 32'(fea_v[idx]), 32'(fea));
            check({tag, "_first_phase"}, 32'(fep_v[idx]), 32'(fep));
        end
        check({tag, "_pass"}, 32'(pass_v[idx]), 32'(pas));
    endtask

    initial begin
        int d, r, b;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_done", 32'(done_v), 32'h0);
        check("rst_pass", 32'(pass_v), 32'h0);
        check("rst_wr_en", 32'(wr_en_v), 32'h0);
        check("rst_addr", 32'(addr_v[0]), 32'h0);
        check("rst_wr_data", 32'(wr_data_v[0]), 32'h0);
        check("rst_err_count", 32'(cnt_v[0]), 32'h0);
        check("rst_first_valid", 32'(fev_v), 32'h0);
        rst = 1'b0;
        step();

        // 1: clean memory
        fault_mode = 0;
        rc = 0;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        check("t1_first_wr_en", 32'(wr_en_v[0]), 32'h1);
        check("t1_first_wr_data", 32'(wr_data_v[0]), 32'hA5);
        check("t1_busy", 32'(busy_v[0]), 32'h1);
        while (rc < 49) step();
        check("t1_ph1_wr_data", 32'(wr_data_v[0]), 32'h5A);
        check("t1_ph1_wr_addr", 32'(addr_v[0]), 32'h0);
        while (done_v[0] !== 1'b1 && rc < 400) step();
        check("t1_done_cycle", 32'(rc), 32'd97);
        step();
        check("t1_done_pulse", 32'(done_v[0]), 32'h0);
        check("t1_busy_after", 32'(busy_v[0]), 32'h0);
        check_res(0, "t1", 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // 2: permanent zero-to-one fault on bit 0
        fault_mode = 1;
        run_test(0, 1'b0, 1'b0, d, r, b);
        check("t2_done_cycle", 32'(d), 32'd97);
        check_res(0, "t2", 16, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        check("t2_addr_runs", 32'(r), 32'd32);
        check("t2_addr_hold_bad", 32'(b), 32'd0);

        // 3: extra starts while busy and in DONE are ignored
        fault_mode = 0;
        run_test(0, 1'b1, 1'b1, d, r, b);
        check("t3_done_cycle", 32'(d), 32'd97);
        check("t3_start_in_done", 32'(busy_v[0]), 32'h0);
        check_res(0, "t3", 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // 4: reset in phase-1 RD at a=7
        fault_mode = 1;
        rc = 0;
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        while (rc < 79) step();
        check("t4_addr_at_rst", 32'(addr_v[0]), 32'd7);
        check("t4_rd_state", 32'(wr_en_v[0]), 32'h0);
        check("t4_count_before", 32'(cnt_v[0]), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t4_busy", 32'(busy_v[0]), 32'h0);
        check("t4_wr_en", 32'(wr_en_v[0]), 32'h0);
        check("t4_err_count", 32'(cnt_v[0]), 32'h0);
        check("t4_first_valid", 32'(fev_v[0]), 32'h0);
        fault_mode = 0;
        run_test(0, 1'b0, 1'b0, d, r, b);
        check("t4_rerun_done", 32'(d), 32'd97);
        check_res(0, "t4_rerun", 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // 5: fault only during the phase-0 read of address 3
        fault_mode = 2;
        run_test(0, 1'b0, 1'b0, d, r, b);
        check("t5_done_cycle", 32'(d), 32'd97);
        check_res(0, "t5", 1, 1'b1, 1'b1, 3, 1'b0, 1'b0);
        fault_mode = 0;

        // 6: zero and two-cycle read latency builds
        run_test(1, 1'b0, 1'b0, d, r, b);
        check("t6_lat0_done", 32'(d), 32'd65);
        check("t6_lat0_runs", 32'(r), 32'd32);
        check("t6_lat0_hold_bad", 32'(b), 32'd0);
        check_res(1, "t6_lat0", 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        run_test(2, 1'b0, 1'b0, d, r, b);
        check("t6_lat2_done", 32'(d), 32'd129);
        check("t6_lat2_runs", 32'(r), 32'd32);
        check("t6_lat2_hold_bad", 32'(b), 32'd0);
        check_res(2, "t6_lat2", 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
